fetch_stage: RTL and testbench

// IF stage of the 5-stage RV32I pipeline: owns the PC, issues instruction-memory requests over a

---
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 tb/tb_fetch_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage of the RV32I pipeline: owns the PC, talks to instruction memory over valid/ready
// and loads the IF/ID register, honouring stalls, flushes and EX-stage redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic        JalrE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] JalrTargetE,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchBusyF
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_KILL, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   buf_q, buf_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pcd_q, pcd_d;
  logic [XLEN-1:0]   pcp4d_q, pcp4d_d;
  logic              validd_q, validd_d;

  logic              redirect_c;
  logic [XLEN-1:0]   target_raw_c;
  logic [XLEN-1:0]   target_c;
  logic [XLEN-1:0]   pc_plus4_c;
  logic              load_c;
  logic [XLEN-1:0]   load_data_c;

  // Redirect target: JALR wins over branch/JAL; result is always word aligned.
  always_comb begin
    redirect_c   = JalrE | PCSrcE;
    target_raw_c = JalrE ? (JalrTargetE & 32'hFFFF_FFFE) : PCTargetE;
    target_c     = target_raw_c & 32'hFFFF_FFFC;
    pc_plus4_c   = XLEN'(pc_q + 32'd4);
    load_c       = !rst && !redirect_c && !FlushD && !StallD &&
                   (((state_q == S_WAIT) && imem_rsp_valid) || (state_q == S_HOLD));
    load_data_c  = (state_q == S_HOLD) ? buf_q : imem_rsp_data;
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      buf_q    <= '0;
      instr_q  <= NOP_INSTR;
      pcd_q    <= '0;
      pcp4d_q  <= '0;
      validd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      buf_q    <= buf_d;
      instr_q  <= instr_d;
      pcd_q    <= pcd_d;
      pcp4d_q  <= pcp4d_d;
      validd_q <= validd_d;
    end
  end

  // Next-state and datapath. A flushed response is not consumed, so the PC is refetched.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf_d    = buf_q;
    instr_d  = instr_q;
    pcd_d    = pcd_q;
    pcp4d_d  = pcp4d_q;
    validd_d = validd_q;

    case (state_q)
      S_REQ: begin
        if (redirect_c) begin
          pc_d = target_c;
        end else if (!StallF && imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_c) begin
          pc_d    = target_c;
          state_d = imem_rsp_valid ? S_REQ : S_KILL;
        end else if (imem_rsp_valid) begin
          if (FlushD) begin
            state_d = S_REQ;
          end else if (StallD) begin
            buf_d   = imem_rsp_data;
            state_d = S_HOLD;
          end else begin
            pc_d    = pc_plus4_c;
            state_d = S_REQ;
          end
        end
      end
      S_KILL: begin
        if (redirect_c) begin
          pc_d = target_c;
        end
        if (imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect_c) begin
          pc_d    = target_c;
          state_d = S_REQ;
        end else if (!StallD) begin
          if (!FlushD) begin
            pc_d = pc_plus4_c;
          end
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // IF/ID: flush > stall > load > bubble (PC fields keep their value on a bubble).
    if (FlushD) begin
      instr_d  = NOP_INSTR;
      validd_d = 1'b0;
    end else if (StallD) begin
      instr_d  = instr_q;
    end else if (load_c) begin
      instr_d  = load_data_c;
      pcd_d    = pc_q;
      pcp4d_d  = pc_plus4_c;
      validd_d = 1'b1;
    end else begin
      instr_d  = NOP_INSTR;
      validd_d = 1'b0;
    end
  end

  // Request port and busy flag; a redirect suppresses the request to the stale PC.
  always_comb begin
    imem_req_valid = !rst && (state_q == S_REQ) && !StallF && !redirect_c;
    imem_req_addr  = pc_q;
    FetchBusyF     = rst || (!load_c && !StallD);
    InstrD         = instr_q;
    PCD            = pcd_q;
    PCPlus4D       = pcp4d_q;
    ValidD         = validd_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays instruction memory by hand, cycle by cycle.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        StallF, StallD, FlushD, PCSrcE, JalrE;
  logic [31:0] PCTargetE, JalrTargetE;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, FetchBusyF;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .StallF         (StallF),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .PCSrcE         (PCSrcE),
    .JalrE          (JalrE),
    .PCTargetE      (PCTargetE),
    .JalrTargetE    (JalrTargetE),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .ValidD         (ValidD),
    .FetchBusyF     (FetchBusyF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fetch from REQ: request at a, response lat cycles after accept carrying d.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int lat);
    logic [31:0] a4;
    a4 = 32'(a + 32'd4);
    imem_rsp_valid = 1'b0;
    #1;
    chk("req_valid", 32'(imem_req_valid), 32'd1);
    chk("req_addr", imem_req_addr, a);
    chk("busy_req", 32'(FetchBusyF), 32'd1);
    step();
    chk("bubble_valid", 32'(ValidD), 32'd0);
    for (int i = 1; i < lat; i++) begin
      #1;
      chk("busy_wait", 32'(FetchBusyF), 32'd1);
      chk("no_req_wait", 32'(imem_req_valid), 32'd0);
      step();
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = d;
    #1;
    chk("busy_rsp", 32'(FetchBusyF), 32'd0);
    step();
    imem_rsp_valid = 1'b0;
    chk("InstrD", InstrD, d);
    chk("PCD", PCD, a);
    chk("PCPlus4D", PCPlus4D, a4);
    chk("ValidD", 32'(ValidD), 32'd1);
  endtask

  initial begin
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcE = 1'b0; JalrE = 1'b0; PCTargetE = '0; JalrTargetE = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    // Reset state
    step(); step();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_busy", 32'(FetchBusyF), 32'd1);
    chk("rst_InstrD", InstrD, NOP);
    chk("rst_PCD", PCD, 32'd0);
    chk("rst_PCPlus4D", PCPlus4D, 32'd0);
    chk("rst_ValidD", 32'(ValidD), 32'd0);
    rst = 1'b0;

    // Backpressure keeps the request up; StallF suppresses it
    imem_req_ready = 1'b0;
    #1;
    chk("bp_valid", 32'(imem_req_valid), 32'd1);
    step();
    imem_req_ready = 1'b1;
    #1;
    chk("bp_addr_held", imem_req_addr, 32'd0);
    StallF = 1'b1;
    #1;
    chk("stallf_no_req", 32'(imem_req_valid), 32'd0);
    step();
    StallF = 1'b0;

    // Latency 1 stream
    fetch(32'h0, 32'hA000_0000, 1);
    fetch(32'h4, 32'hA000_0004, 1);
    fetch(32'h8, 32'hA000_0008, 1);

    // Latency 3 after a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    fetch(32'h0, 32'hB000_0000, 3);
    fetch(32'h4, 32'hB000_0004, 3);

    // Branch redirect while waiting: stale response dropped, unaligned target aligned
    #1;
    chk("t3_addr", imem_req_addr, 32'h8);
    step();
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0102;
    #1;
    chk("t3_busy", 32'(FetchBusyF), 32'd1);
    step();
    PCSrcE = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    #1;
    chk("t3_kill_busy", 32'(FetchBusyF), 32'd1);
    chk("t3_kill_noreq", 32'(imem_req_valid), 32'd0);
    step();
    imem_rsp_valid = 1'b0;
    chk("t3_drop_valid", 32'(ValidD), 32'd0);
    chk("t3_drop_instr", InstrD, NOP);
    fetch(32'h100, 32'hC000_0100, 1);

    // JALR with same-cycle response; JALR beats branch
    #1;
    chk("t4_addr", imem_req_addr, 32'h104);
    step();
    JalrE = 1'b1; JalrTargetE = 32'h0000_0203;
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0300;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0104;
    #1;
    chk("t4_busy", 32'(FetchBusyF), 32'd1);
    step();
    JalrE = 1'b0; PCSrcE = 1'b0; imem_rsp_valid = 1'b0;
    chk("t4_valid", 32'(ValidD), 32'd0);
    chk("t4_instr", InstrD, NOP);
    #1;
    chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t4_req_addr", imem_req_addr, 32'h200);

    // StallD across the response: buffered, then delivered on release
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hD500_0200; StallD = 1'b1;
    #1;
    chk("t5_busy_stalled", 32'(FetchBusyF), 32'd0);
    step();
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t5_hold_noreq", 32'(imem_req_valid), 32'd0);
      chk("t5_hold_instr", InstrD, NOP);
      chk("t5_hold_pcd", PCD, 32'h100);
      step();
    end
    StallD = 1'b0;
    #1;
    chk("t5_release_busy", 32'(FetchBusyF), 32'd0);
    step();
    chk("t5_instr", InstrD, 32'hD500_0200);
    chk("t5_pcd", PCD, 32'h200);
    chk("t5_pcp4", PCPlus4D, 32'h204);
    chk("t5_valid", 32'(ValidD), 32'd1);
    #1;
    chk("t5_next_addr", imem_req_addr, 32'h204);

    // FlushD with a response, then reset while waiting
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hF100_0204; FlushD = 1'b1;
    #1;
    chk("t6_busy", 32'(FetchBusyF), 32'd1);
    step();
    imem_rsp_valid = 1'b0; FlushD = 1'b0;
    chk("t6_instr", InstrD, NOP);
    chk("t6_valid", 32'(ValidD), 32'd0);
    step();
    rst = 1'b1;
    #1;
    chk("t6_rst_noreq", 32'(imem_req_valid), 32'd0);
    chk("t6_rst_busy", 32'(FetchBusyF), 32'd1);
    step();
    rst = 1'b0;
    #1;
    chk("t6_rst_req", 32'(imem_req_valid), 32'd1);
    chk("t6_rst_pc", imem_req_addr, 32'h0);

    // Redirect in REQ to the top word, then PC wraps to zero
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    #1;
    chk("wrap_noreq", 32'(imem_req_valid), 32'd0);
    step();
    PCSrcE = 1'b0;
    fetch(32'hFFFF_FFFC, 32'hE000_0FFC, 2);
    #1;
    chk("wrap_next_addr", imem_req_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
